// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch/decode/execute sequencer for a 16-word program
//
// Runs a three-cycle FETCH -> DECODE -> EXEC loop over a 16-entry instruction
// memory and emits register-file writes for MOVI.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     run request, honoured only in IDLE or HALT
//   stop      stop request, latched while running; takes effect after EXEC
//   op        instruction word read combinationally at pc_out
//   pc_out    instruction memory address (always equals PC)
//   rf_we     register-file write strobe, one cycle per MOVI
//   rf_waddr  register-file write address (holds when rf_we=0)
//   rf_wdata  register-file write data (holds when rf_we=0)
//   busy      high in FETCH, DECODE, EXEC
//   halted    high in HALT
module fetch_ctrl #(
  parameter logic [3:0] RESET_PC = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] op,
  output logic [3:0]  pc_out,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [3:0]  rf_wdata,
  output logic        busy,
  output logic        halted
);

  localparam logic [3:0] OPC_MOVI = 4'd0;
  localparam logic [3:0] OPC_JMP  = 4'd1;
  localparam logic [3:0] OPC_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  pc, pc_nx;
  logic        stop_pend, stop_pend_nx;
  logic [31:0] ir;
  logic [3:0]  opc_q, rd_q, imm_q, tgt_q;
  logic [3:0]  wa_hold, wd_hold;

  // Operand bits between imm4 and target carry no meaning for any opcode.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[19:4];

  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    stop_pend_nx = stop_pend;
    case (state)
      S_IDLE, S_HALT: begin
        stop_pend_nx = 1'b0;
        if (start) begin
          state_nx = S_FETCH;
          pc_nx    = RESET_PC;
        end
      end
      S_FETCH: begin
        state_nx = S_DECODE;
        if (stop) stop_pend_nx = 1'b1;
      end
      S_DECODE: begin
        state_nx = S_EXEC;
        if (stop) stop_pend_nx = 1'b1;
      end
      S_EXEC: begin
        // The instruction always completes; a stop seen this cycle counts too.
        stop_pend_nx = 1'b0;
        case (opc_q)
          OPC_JMP:  pc_nx = tgt_q;
          OPC_HALT: pc_nx = pc;
          default:  pc_nx = pc + 4'd1;
        endcase
        if (opc_q == OPC_HALT)
          state_nx = S_HALT;
        else if (stop_pend || stop)
          state_nx = S_IDLE;
        else
          state_nx = S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      stop_pend <= 1'b0;
      ir        <= 32'd0;
      opc_q     <= 4'd0;
      rd_q      <= 4'd0;
      imm_q     <= 4'd0;
      tgt_q     <= 4'd0;
      wa_hold   <= 4'd0;
      wd_hold   <= 4'd0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      stop_pend <= stop_pend_nx;
      if (state == S_FETCH) ir <= op;
      if (state == S_DECODE) begin
        opc_q <= ir[31:28];
        rd_q  <= ir[27:24];
        imm_q <= ir[23:20];
        tgt_q <= ir[3:0];
      end
      if (rf_we) begin
        wa_hold <= rd_q;
        wd_hold <= imm_q;
      end
    end
  end

  // Strobe decoded from registered state so a reset drops it immediately.
  assign rf_we    = (state == S_EXEC) && (opc_q == OPC_MOVI);
  assign rf_waddr = rf_we ? rd_q  : wa_hold;
  assign rf_wdata = rf_we ? imm_q : wd_hold;
  assign pc_out   = pc;
  assign busy     = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
  assign halted   = (state == S_HALT);

endmodule
